// File: rtl/fetch_unit.sv
// Instruction fetch unit: IDLE/FETCH/VALID/UPDATE sequencer that fetches a
// half-word instruction at PC, holds it in IR, and applies the next-PC choice.
module fetch_unit #(
  parameter logic [15:0] RESET_PC = 16'h0000,
  parameter int unsigned PC_STEP  = 2
) (
  input  logic        CLK,
  input  logic        Reset,
  input  logic        Start,
  input  logic        MemReady,
  input  logic [15:0] MemData,
  input  logic        Advance,
  input  logic [1:0]  PCSrc,
  input  logic        Zero,
  input  logic [15:0] BranchTarget,
  input  logic [15:0] JumpAddr,
  output logic        MemRead,
  output logic [15:0] MemAddr,
  output logic [15:0] PC,
  output logic [15:0] IR,
  output logic        IRValid,
  output logic [13:0] LeftShiftedIR,
  output logic [1:0]  TwoBitsPC
);

  localparam int unsigned W = 16;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    FETCH  = 2'd1,
    VALID  = 2'd2,
    UPDATE = 2'd3
  } state_e;

  state_e       state_q, state_d;
  logic [W-1:0] pc_q, pc_d;
  logic [W-1:0] ir_q, ir_d;
  logic [W-1:0] pend_q, pend_d;
  logic         mem_read_q, mem_read_d;
  logic         ir_valid_q, ir_valid_d;
  logic [W-1:0] pc_seq;
  logic [W-1:0] pc_sel;

  // Next-PC candidate; wraps modulo 2^16 and is forced half-word aligned.
  always_comb begin
    pc_seq = W'(pc_q + W'(PC_STEP));
    pc_sel = pc_seq;
    case (PCSrc)
      2'b00:   pc_sel = pc_seq;
      2'b01:   pc_sel = Zero ? BranchTarget : pc_seq;
      2'b10:   pc_sel = JumpAddr;
      default: pc_sel = pc_q;
    endcase
    pc_sel[0] = 1'b0;
  end

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    ir_d    = ir_q;
    pend_d  = pend_q;
    case (state_q)
      IDLE: begin
        if (Start) state_d = FETCH;
      end
      FETCH: begin
        if (MemReady) begin
          ir_d    = MemData;
          state_d = VALID;
        end
      end
      VALID: begin
        if (Advance) begin
          pend_d  = pc_sel;
          state_d = UPDATE;
        end
      end
      UPDATE: begin
        pc_d    = pend_q;
        state_d = Start ? FETCH : IDLE;
      end
      default: state_d = IDLE;
    endcase
    // Status flags are registered alongside the state they decode.
    mem_read_d = (state_d == FETCH);
    ir_valid_d = (state_d == VALID);
  end

  always_ff @(posedge CLK or posedge Reset) begin
    if (Reset) begin
      state_q    <= IDLE;
      pc_q       <= RESET_PC;
      ir_q       <= '0;
      pend_q     <= RESET_PC;
      mem_read_q <= 1'b0;
      ir_valid_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      ir_q       <= ir_d;
      pend_q     <= pend_d;
      mem_read_q <= mem_read_d;
      ir_valid_q <= ir_valid_d;
    end
  end

  assign MemRead       = mem_read_q;
  assign MemAddr       = pc_q;
  assign PC            = pc_q;
  assign IR            = ir_q;
  assign IRValid       = ir_valid_q;
  assign LeftShiftedIR = {ir_q[11:0], 2'b00};
  assign TwoBitsPC     = pc_q[15:14];

endmodule

// File: tb/tb_fetch_unit.sv
// Directed self-checking bench for fetch_unit with hand-computed expectations.
module tb_fetch_unit;

  logic        CLK = 1'b0;
  logic        Reset;
  logic        Start;
  logic        MemReady;
  logic [15:0] MemData;
  logic        Advance;
  logic [1:0]  PCSrc;
  logic        Zero;
  logic [15:0] BranchTarget;
  logic [15:0] JumpAddr;
  logic        MemRead;
  logic [15:0] MemAddr;
  logic [15:0] PC;
  logic [15:0] IR;
  logic        IRValid;
  logic [13:0] LeftShiftedIR;
  logic [1:0]  TwoBitsPC;

  int checks   = 0;
  int failures = 0;

  fetch_unit dut (
    .CLK(CLK), .Reset(Reset), .Start(Start), .MemReady(MemReady),
    .MemData(MemData), .Advance(Advance), .PCSrc(PCSrc), .Zero(Zero),
    .BranchTarget(BranchTarget), .JumpAddr(JumpAddr), .MemRead(MemRead),
    .MemAddr(MemAddr), .PC(PC), .IR(IR), .IRValid(IRValid),
    .LeftShiftedIR(LeftShiftedIR), .TwoBitsPC(TwoBitsPC)
  );

  always #5 CLK = ~CLK;

  task automatic check_eq(input string tag, input logic [15:0] got, input logic [15:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got=%h expected=%h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  // From FETCH: deliver a word, then advance with the given next-PC choice; ends in FETCH.
  task automatic fetch_adv(input logic [15:0] data, input logic [1:0] src, input logic z,
                           input logic [15:0] bt, input logic [15:0] ja);
    MemReady = 1'b1; MemData = data;
    step();
    MemReady = 1'b0;
    Advance = 1'b1; PCSrc = src; Zero = z; BranchTarget = bt; JumpAddr = ja;
    step();
    Advance = 1'b0;
    step();
  endtask

  initial begin
    Reset = 1'b1; Start = 1'b0; MemReady = 1'b0; MemData = '0; Advance = 1'b0;
    PCSrc = 2'b00; Zero = 1'b0; BranchTarget = '0; JumpAddr = '0;
    #1;
    check_eq("rst_pc", PC, 16'h0000);
    check_eq("rst_ir", IR, 16'h0000);
    check_eq("rst_memread", 16'(MemRead), 16'h0);
    check_eq("rst_irvalid", 16'(IRValid), 16'h0);
    step(); step();
    Reset = 1'b0;
    step();
    check_eq("idle_no_start", 16'(MemRead), 16'h0);

    // First fetch: MemReady on the second FETCH cycle.
    Start = 1'b1;
    step();
    check_eq("fetch_memread", 16'(MemRead), 16'h1);
    check_eq("fetch_addr0", MemAddr, 16'h0000);
    step();
    check_eq("fetch_wait", 16'(MemRead), 16'h1);
    MemReady = 1'b1; MemData = 16'h3A5C;
    step();
    MemReady = 1'b0;
    check_eq("ir_load", IR, 16'h3A5C);
    check_eq("irvalid", 16'(IRValid), 16'h1);
    check_eq("valid_memread", 16'(MemRead), 16'h0);
    check_eq("lsir_2970", 16'(LeftShiftedIR), 16'h2970);
    check_eq("twobits_0", 16'(TwoBitsPC), 16'h0);

    // MemReady in VALID ignored; Advance+MemReady together acts as VALID only.
    MemReady = 1'b1; MemData = 16'hFFFF;
    step();
    check_eq("valid_ignore_mr", IR, 16'h3A5C);
    Advance = 1'b1; PCSrc = 2'b10; JumpAddr = 16'h0010;
    step();
    MemReady = 1'b0; Advance = 1'b0;
    check_eq("update_ir_stable", IR, 16'h3A5C);
    check_eq("update_irvalid", 16'(IRValid), 16'h0);
    check_eq("update_pc_old", PC, 16'h0000);
    step();
    check_eq("jump_0010", PC, 16'h0010);

    // Advance in FETCH ignored.
    Advance = 1'b1; PCSrc = 2'b10; JumpAddr = 16'h5550;
    step();
    Advance = 1'b0;
    check_eq("fetch_ignore_adv", 16'(MemRead), 16'h1);

    fetch_adv(16'h0001, 2'b00, 1'b0, 16'h0000, 16'h0000);
    check_eq("seq_0012", PC, 16'h0012);
    check_eq("seq_addr", MemAddr, 16'h0012);
    fetch_adv(16'h0002, 2'b01, 1'b0, 16'h0200, 16'h0000);
    check_eq("br_nz", PC, 16'h0014);
    fetch_adv(16'h0003, 2'b01, 1'b1, 16'h0200, 16'h0000);
    check_eq("br_z", PC, 16'h0200);
    fetch_adv(16'h0004, 2'b10, 1'b0, 16'h0000, 16'hC004);
    check_eq("jump_c004", PC, 16'hC004);

    // Jump from PC=0xC004 with IR=0x1123.
    MemReady = 1'b1; MemData = 16'h1123;
    step();
    MemReady = 1'b0;
    check_eq("twobits_11", 16'(TwoBitsPC), 16'h3);
    check_eq("lsir_048c", 16'(LeftShiftedIR), 16'h048C);
    Advance = 1'b1; PCSrc = 2'b10; JumpAddr = 16'hC48C;
    step();
    Advance = 1'b0;
    step();
    check_eq("jump_c48c", PC, 16'hC48C);

    fetch_adv(16'h0005, 2'b10, 1'b0, 16'h0000, 16'hFFFE);
    check_eq("jump_fffe", PC, 16'hFFFE);
    fetch_adv(16'h0006, 2'b00, 1'b0, 16'h0000, 16'h0000);
    check_eq("wrap_0000", PC, 16'h0000);
    fetch_adv(16'h0007, 2'b10, 1'b0, 16'h0000, 16'h0101);
    check_eq("align_0100", PC, 16'h0100);
    fetch_adv(16'h0008, 2'b01, 1'b1, 16'h0333, 16'h0000);
    check_eq("br_align_0332", PC, 16'h0332);
    fetch_adv(16'h0009, 2'b11, 1'b1, 16'h0400, 16'h0600);
    check_eq("hold", PC, 16'h0332);
    check_eq("hold_fetch", 16'(MemRead), 16'h1);

    // Reset mid-FETCH, asynchronously, then a late MemReady.
    #3;
    Reset = 1'b1;
    #1;
    check_eq("async_memread", 16'(MemRead), 16'h0);
    check_eq("async_pc", PC, 16'h0000);
    check_eq("async_ir", IR, 16'h0000);
    step();
    Start = 1'b0; MemReady = 1'b1; MemData = 16'hBEEF;
    Reset = 1'b0;
    step();
    check_eq("late_mr_memread", 16'(MemRead), 16'h0);
    check_eq("late_mr_ir", IR, 16'h0000);
    MemReady = 1'b0; Start = 1'b1;
    step();
    check_eq("refetch_memread", 16'(MemRead), 16'h1);
    check_eq("refetch_addr", MemAddr, 16'h0000);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 The module SHALL have parameter RESET_PC, default 16'h0000, giving the PC value loaded on reset.
REQ-002 The module SHALL have parameter PC_STEP, default 2, giving the sequential PC increment in bytes.
REQ-003 Port CLK, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 Port Reset, input, 1 bit: the reset, asynchronous and active-high.
REQ-005 Port Start, input, 1: a level that enables leaving IDLE.
REQ-006 Port MemReady, input, 1: instruction memory has MemData valid this cycle.
REQ-007 Port MemData, input, 16: instruction word from memory.
REQ-008 Port Advance, input, 1: the downstream stage consumes the current IR and supplies the next-PC choice.
REQ-009 Port PCSrc, input, 2: next-PC select, where 00 = sequential, 01 = branch if Zero, 10 = jump, and 11 = hold.
REQ-010 Port Zero, input, 1: the accumulator-zero flag qualifying a branch.
REQ-011 Port BranchTarget, input, 16: the branch destination address.
REQ-012 Port JumpAddr, input, 16: the jump destination, which is the concatenated {PC[15:14], IR[11:0], 2'b00} address returned from the concatenation stage.
REQ-013 Port MemRead, output, 1: the fetch request.
REQ-014 Port MemAddr, output, 16: the fetch address.
REQ-015 Port PC, output, 16: the current program counter.
REQ-016 Port IR, output, 16: the latched instruction.
REQ-017 Port IRValid, output, 1: IR holds an unconsumed instruction.
REQ-018 Port LeftShiftedIR, output, 14: {IR[11:0], 2'b00}.
REQ-019 Port TwoBitsPC, output, 2: PC[15:14].

Function
REQ-020 The FSM SHALL have states IDLE, FETCH, VALID and UPDATE, all registered.
REQ-021 In IDLE, the FSM SHALL go to FETCH on the first edge with Start=1, and remain in IDLE otherwise.
REQ-022 In FETCH, MemRead SHALL be 1, MemAddr SHALL equal PC, and the FSM SHALL stay in FETCH until MemReady=1.
REQ-023 On the FETCH edge with MemReady=1, IR SHALL load MemData and the FSM SHALL enter VALID, giving 1-cycle latency from MemReady to IRValid.
REQ-024 In VALID, IRValid SHALL be 1 and IR SHALL stay stable; the FSM SHALL stay in VALID until Advance=1.
REQ-025 On the VALID edge with Advance=1, the FSM SHALL sample PCSrc, Zero, BranchTarget and JumpAddr into a pending-next-PC register and enter UPDATE.
REQ-026 In UPDATE, PC SHALL load the pending value, and the FSM SHALL return to FETCH if Start=1, else to IDLE.
REQ-027 The next PC SHALL be: PC+PC_STEP for 00, and also for 01 when Zero=0; BranchTarget for 01 with Zero=1; JumpAddr for 10; PC unchanged for 11.
REQ-028 PC arithmetic SHALL be modulo 2^16, so that 16'hFFFE + 2 = 16'h0000.
REQ-029 PC bit 0 SHALL always be written 0, whatever the source value (half-word alignment).
REQ-030 MemReady outside FETCH and Advance outside VALID SHALL be ignored.
REQ-031 Advance and MemReady asserted in the same cycle SHALL act only according to the current state.
REQ-032 MemRead SHALL be 0 and IRValid SHALL be 0 in every state except FETCH and VALID respectively.
REQ-033 LeftShiftedIR and TwoBitsPC SHALL be combinational functions of the registered IR and PC only.

Reset
REQ-034 While Reset=1, the outputs SHALL immediately (asynchronously) be: state=IDLE, PC=RESET_PC, IR=16'h0000, MemRead=0, IRValid=0, and pending-next-PC=RESET_PC.
REQ-035 Reset asserted during FETCH or VALID SHALL abort the operation with no PC update, and MemRead SHALL fall without waiting for a clock edge.
REQ-036 After Reset deasserts, the first fetch SHALL occur only after Start=1 is sampled.

Verification
REQ-037 Scenario: reset, Start=1, MemReady=1 on the 2nd FETCH cycle with MemData=16'h3A5C -> MemAddr=0x0000, IR=0x3A5C, IRValid=1, LeftShiftedIR=14'h2970, TwoBitsPC=0.
REQ-038 Scenario: Advance with PCSrc=00 from PC=0x0010 -> PC=0x0012 after UPDATE, and the next MemAddr=0x0012.
REQ-039 Scenario: PCSrc=01, BranchTarget=0x0200: with Zero=0, PC becomes PC+2; with Zero=1, PC=0x0200.
REQ-040 Scenario: PC=0xC004, IR=16'h1123, PCSrc=10, JumpAddr=0xC48C -> PC=0xC48C, and TwoBitsPC=2'b11 before the update.
REQ-041 Scenario: PC=0xFFFE with PCSrc=00 -> PC=0x0000; JumpAddr=0x0101 -> PC=0x0100.
REQ-042 Scenario: Reset pulsed mid-FETCH with MemRead=1 -> MemRead=0 and PC=RESET_PC before the next edge, and a late MemReady is ignored.
